mdu_stall_ctrl: RTL and testbench
=================================

# mdu_stall_ctrl

Iterative multiply/divide unit for the pipelined MIPS32 core. It sits in the EX stage and owns the HI/LO registers. It produces `stall`, which the hazard logic inverts to drive the `en` inputs of the PC, IF/ID and ID/EX pipeline registers, freezing the front of the pipeline while an operation runs. It executes MULT, MULTU, DIV and DIVU in 32 iterations, and supports MTHI/MTLO writes.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits. The iteration count equals `WIDTH`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-low.
- `start` in 1: EX holds a mult/div instruction.
- `op` in 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: rs operand (multiplicand or dividend).
- `b` in WIDTH: rt operand (multiplier or divisor).
- `hi_we` in 1: MTHI write strobe.
- `lo_we` in 1: MTLO write strobe.
- `wd` in WIDTH: MTHI/MTLO write data.
- `stall` out 1: hold the upstream pipeline registers. Upstream `en = ~stall`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse. HI/LO hold a new result.
- `hi` out WIDTH: HI register value.
- `lo` out WIDTH: LO register value.

## Operation
- States:
  - IDLE: waiting for an operation.
  - RUN: iterating, with a 5-bit counter `cnt` (log2 `WIDTH`).
  - DONE: one cycle, result visible.
- IDLE with `start`=1:
  - Latch |a| and |b|. Absolute values are taken only for signed ops.
  - Latch the result sign flags and `op`.
  - Set `cnt`=0 and go to RUN.
- RUN:
  - One iteration per cycle.
  - Multiply is shift-add into a 2·WIDTH product.
  - Divide is restoring, producing 1 quotient bit per cycle.
  - When `cnt`==WIDTH-1: apply sign correction, write HI/LO, go to DONE.
- DONE: go to IDLE unconditionally. `start` is ignored here, because it is still asserted by the same instruction.
- `start` is ignored in RUN and DONE. No re-launch is possible until IDLE.
- Multiply results:
  - HI:LO = 64-bit product.
  - MULT gives the signed two's-complement product. MULTU gives the unsigned product.
- Divide results:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
- Divide by zero (DIV or DIVU): LO = all ones, HI = `a` unchanged. Takes the full 32 iterations, with no early exit.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO:
  - A write happens only in IDLE with `start`=0. `hi_we` loads HI from `wd`; `lo_we` loads LO from `wd`. Both may write in the same cycle.
  - Strobes are ignored in RUN and DONE.
  - If `start` and a write strobe arrive together, `start` wins and the write is dropped.
- HI/LO change only on a result write (end of RUN), an MTHI/MTLO write, or reset.

## Timing
- Reset (`rst`=0 at a rising edge): state = IDLE, `cnt`=0, `hi`=0, `lo`=0, `busy`=0, `done`=0. `stall` is 0 once `start`=0.
- Reset during RUN aborts the operation at that edge. No partial result reaches HI/LO.
- `stall` is combinational: `(IDLE & start) | RUN`.
- Cycle timeline, taking cycle 0 as the first cycle with `start`=1 in IDLE:
  - Cycle 0: `stall`=1.
  - Cycles 1–32: RUN. `stall`=1, `busy`=1.
  - Cycle 33: DONE. `done`=1, `stall`=0, `hi`/`lo` show the result.
  - Cycle 34: IDLE.
- The pipeline is therefore frozen for exactly 33 cycles. The instruction after the mult/div reaches EX in cycle 34.
- An MFHI/MFLO in cycle 34 or later reads the new result.
- Back-to-back ops: a second `start` in cycle 34 launches immediately, again with 33 stall cycles.
- `busy` and `done` are registered outputs. `hi` and `lo` are registered outputs.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `stall` high for cycles 0–32; in cycle 33, `done`=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x00000064 after 32 RUN cycles. Then DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI wd=0x12345678 in IDLE → hi=0x12345678 next cycle. `hi_we`=1 during RUN → no change. `start` and `lo_we` in the same cycle → operation starts, LO is not written.
- Start MULTU 5×6, drive `rst`=0 in cycle 10 → next cycle IDLE, hi=lo=0, `stall`=0. Relaunch completes with lo=30, hi=0 in cycle 33 of the new op.
- Hold `start`=1 through DONE → no second launch. A new `start` in cycle 34 gives `stall` rising the same cycle and `done` in cycle 67.

Source files
------------

// File: rtl/mdu_stall_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 32 iterations per operation.
// Raises stall to freeze PC, IF/ID and ID/EX while an operation is in flight.
module mdu_stall_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = {CW{1'b1}};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? neg_w(x) : x;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [CW-1:0]      cnt_r;
  logic               op_div_r;
  logic [WIDTH-1:0]   abs_a_r;
  logic [WIDTH-1:0]   abs_b_r;
  logic [WIDTH-1:0]   a_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               div_zero_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               stall_s;
  logic               last_s;
  logic               sgn_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [2*WIDTH-1:0] step_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  // State register with registered busy/done derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode: stall covers the launch cycle and every RUN cycle.
  always_comb begin
    stall_s = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      ST_IDLE: stall_s = start;
      ST_RUN: begin
        stall_s = 1'b1;
        last_s  = (cnt_r == CNT_LAST);
      end
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Operand conditioning at launch: magnitudes only for the signed ops.
  always_comb begin
    sgn_s   = ~op[0];
    abs_a_s = abs_w(a, sgn_s);
    abs_b_s = abs_w(b, sgn_s);
  end

  // One shift-add or restoring-divide iteration on the shared accumulator.
  always_comb begin
    step_s  = acc_r;
    shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, abs_b_r};
    sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? abs_a_r : W_ZERO)};
    if (op_div_r) begin
      // Upper half is the partial remainder, lower half trades dividend bits for quotient bits.
      if (!diff_s[WIDTH]) begin
        step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the final iteration's value before it lands in HI/LO.
  always_comb begin
    prod_s   = neg_q_r ? neg_d(step_s) : step_s;
    res_hi_s = prod_s[2*WIDTH-1:WIDTH];
    res_lo_s = prod_s[WIDTH-1:0];
    if (op_div_r) begin
      if (div_zero_r) begin
        res_hi_s = a_r;
        res_lo_s = W_ONES;
      end else begin
        res_hi_s = neg_r_r ? neg_w(step_s[2*WIDTH-1:WIDTH]) : step_s[2*WIDTH-1:WIDTH];
        res_lo_s = neg_q_r ? neg_w(step_s[WIDTH-1:0]) : step_s[WIDTH-1:0];
      end
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Datapath: operand latch, iteration, result write and MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r      <= CNT_ZERO;
      op_div_r   <= 1'b0;
      abs_a_r    <= W_ZERO;
      abs_b_r    <= W_ZERO;
      a_r        <= W_ZERO;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      acc_r      <= {W_ZERO, W_ZERO};
      hi_r       <= W_ZERO;
      lo_r       <= W_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cnt_r      <= CNT_ZERO;
            op_div_r   <= op[1];
            abs_a_r    <= abs_a_s;
            abs_b_r    <= abs_b_s;
            a_r        <= a;
            neg_q_r    <= sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r    <= sgn_s & a[WIDTH-1];
            div_zero_r <= (b == W_ZERO);
            acc_r      <= {W_ZERO, (op[1] ? abs_a_s : abs_b_s)};
          end else begin
            if (hi_we) begin
              hi_r <= wd;
            end
            if (lo_we) begin
              lo_r <= wd;
            end
          end
        end
        ST_RUN: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (last_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
          end
        end
        ST_DONE: begin
          cnt_r <= CNT_ZERO;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign stall = stall_s;
  assign busy  = busy_r;
  assign done  = done_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// Scoreboard bench for mdu_stall_ctrl: directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_mdu_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_stall_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int unsigned when;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;
  logic [63:0] last_res = 64'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: {HI, LO} from plain arithmetic on the architectural definition.
  function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint                 p;
    longint unsigned        up;
    logic signed [31:0]     sx;
    logic signed [31:0]     sy;
    logic signed [31:0]     q;
    logic signed [31:0]     r;
    logic [31:0]            uq;
    logic [31:0]            ur;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        p = longint'(sx) * longint'(sy);
        return p;
      end
      2'b01: begin
        up = {32'h0, x};
        up = up * {32'h0, y};
        return up;
      end
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        uq = x / y;
        ur = x % y;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] tbl [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    case ($urandom_range(0, 3))
      0:       return tbl[$urandom_range(0, 4)];
      1:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", {63'h0, done}, 64'h0);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.when));
          chk("result_hi", {32'h0, hi}, {32'h0, e.res[63:32]});
          chk("result_lo", {32'h0, lo}, {32'h0, e.res[31:0]});
        end
      end
    end
  endtask

  // Called at posedge+1 of the launch cycle; strobes here must be dropped.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    hi_we = 1'($urandom_range(0, 1));
    lo_we = 1'($urandom_range(0, 1));
    wd    = $urandom;
    e.res = ref_mdu(o, x, y);
    e.when = cyc + 33;
    sbq.push_back(e);
    last_res = e.res;
  endtask

  task automatic watch(input bit hold);
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      chk("stall", {63'h0, stall}, {63'h0, (k <= 32)});
      chk("busy", {63'h0, busy}, {63'h0, (k >= 1 && k <= 32)});
      if (k >= 1 && k <= 32) begin
        chk("hi_stable", {32'h0, hi}, {32'h0, hi_m});
        chk("lo_stable", {32'h0, lo}, {32'h0, lo_m});
      end
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      if (k < 33) begin
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        wd    = $urandom;
      end else begin
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
    end
    start = 1'b0;
    hi_m  = last_res[63:32];
    lo_m  = last_res[31:0];
  endtask

  task automatic mt(input bit hw, input bit lw, input logic [31:0] d);
    start = 1'b0;
    hi_we = hw;
    lo_we = lw;
    wd    = d;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (hw) hi_m = d;
    if (lw) lo_m = d;
    @(negedge clk);
    chk("mt_hi", {32'h0, hi}, {32'h0, hi_m});
    chk("mt_lo", {32'h0, lo}, {32'h0, lo_m});
    chk("mt_stall", {63'h0, stall}, 64'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    hi_m = 32'h0;
    lo_m = 32'h0;
    @(negedge clk);
    chk("rst_hi", {32'h0, hi}, {32'h0, hi_m});
    chk("rst_lo", {32'h0, lo}, {32'h0, lo_m});
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'h0;
    b     = 32'h0;
    wd    = 32'h0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    fork
      monitor();
      begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
      end
    join_none
    @(posedge clk);
    #1;
    do_reset();

    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    watch(1'b0);
    launch(2'b00, 32'hFFFFFFFD, 32'd7);
    watch(1'b0);
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    watch(1'b0);
    launch(2'b11, 32'd100, 32'd0);
    watch(1'b0);
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    watch(1'b0);
    idle(1);

    mt(1'b1, 1'b0, 32'h12345678);
    mt(1'b0, 1'b1, 32'hCAFEF00D);
    mt(1'b1, 1'b1, 32'hA5A5A5A5);

    // Abort in cycle 10 of a MULTU, then relaunch it.
    launch(2'b01, 32'd5, 32'd6);
    idle(1);
    start = 1'b0;
    idle(9);
    do_reset();
    launch(2'b01, 32'd5, 32'd6);
    watch(1'b0);

    // start held through DONE, then a back-to-back launch in cycle 34.
    launch(2'b11, 32'd1000, 32'd7);
    watch(1'b1);
    launch(2'b00, 32'h80000000, 32'h80000000);
    watch(1'b0);

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      launch(o, x, y);
      watch(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, 3));
      end
    end

    idle(3);
    chk("scoreboard_empty", 64'(sbq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
